// File: rtl/lock_pkg.sv
// Shared definitions for the lock access-sequencing slice.
//   guard_state_t : session state of lock_guard_ctrl
//   KEY_RELOCK    : keypad code that closes an open session early
//   CODE_W        : keypad code width
//   TIMER_W       : session timer / remain width
package lock_pkg;

  localparam int CODE_W  = 4;
  localparam int TIMER_W = 16;

  localparam logic [CODE_W-1:0] KEY_RELOCK = 4'hB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } guard_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing the session timer tick.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   clr   : synchronous restart; the next tick comes TICK_DIV cycles later
//   tick  : high for one cycle when the count is at TICK_DIV-1 (wrap cycle)
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/lock_guard_ctrl.sv
// Access-sequencing controller between keypad scanner and lock decider.
// Gates keys into the decider, consumes its verdicts and runs the session:
// timed unlock window, wrong-attempt counting and escalating lockout.
//   clock, reset          : clock, asynchronous active-low reset
//   valid_in, code_in     : key pulse and code from the scanner
//   verdict_ok/bad        : one-cycle verdict pulses from the decider
//   valid_out, code_out   : gated key stream to the decider (1-cycle lag)
//   unlock, locked_out    : session state flags
//   count_wrong           : consecutive wrong verdicts (saturates at 15)
//   lock_level            : lockout escalation level 0..3
//   remain                : ticks left in OPEN/LOCKOUT, 0 in IDLE
module lock_guard_ctrl
  import lock_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int OPEN_TICKS = 5000,
  parameter int LOCK_TICKS = 30000,
  parameter int MAX_WRONG  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               verdict_ok,
  input  logic               verdict_bad,
  output logic               valid_out,
  output logic [CODE_W-1:0]  code_out,
  output logic               unlock,
  output logic               locked_out,
  output logic [3:0]         count_wrong,
  output logic [1:0]         lock_level,
  output logic [TIMER_W-1:0] remain
);

  guard_state_t        state, state_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic [3:0]          cw_nxt, cw_inc;
  logic [1:0]          lvl_nxt;
  logic                fwd, relock, expire, tick, clr;

  // Restart the prescaler on every state entry so the first tick of a timed
  // state lands exactly TICK_DIV cycles after entry.
  assign clr = (state_nxt != state);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cw_nxt    = count_wrong;
    lvl_nxt   = lock_level;
    fwd       = 1'b0;
    relock    = 1'b0;
    expire    = tick && (timer == TIMER_W'(1));
    cw_inc    = (count_wrong == 4'hF) ? 4'hF : count_wrong + 4'd1;

    unique case (state)
      IDLE: begin
        fwd = valid_in;
        // A wrong verdict wins over a simultaneous correct one.
        if (verdict_bad) begin
          cw_nxt = cw_inc;
          if (cw_inc >= 4'(MAX_WRONG)) begin
            state_nxt = LOCKOUT;
            timer_nxt = TIMER_W'(LOCK_TICKS) << lock_level;
            if (lock_level != 2'd3) lvl_nxt = lock_level + 2'd1;
          end
        end else if (verdict_ok) begin
          state_nxt = OPEN;
          timer_nxt = TIMER_W'(OPEN_TICKS);
          cw_nxt    = '0;
          lvl_nxt   = '0;
        end
      end

      OPEN: begin
        relock = valid_in && (code_in == KEY_RELOCK);
        fwd    = valid_in && !relock;
        // Relock and expiry in the same cycle collapse into one exit.
        if (relock || expire) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (tick) begin
          timer_nxt = timer - TIMER_W'(1);
        end
      end

      LOCKOUT: begin
        if (expire) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          cw_nxt    = '0;
        end else if (tick) begin
          timer_nxt = timer - TIMER_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // NOTE: only control/status registers exist here, so all of them take the
  // asynchronous reset; lock_level is deliberately lost on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      count_wrong <= '0;
      lock_level  <= '0;
      valid_out   <= 1'b0;
      code_out    <= '0;
      unlock      <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      count_wrong <= cw_nxt;
      lock_level  <= lvl_nxt;
      valid_out   <= fwd;
      // code_out keeps the last forwarded key while nothing is forwarded.
      if (fwd) code_out <= code_in;
      unlock      <= (state_nxt == OPEN);
      locked_out  <= (state_nxt == LOCKOUT);
    end
  end

  assign remain = timer;

endmodule

// File: tb/tb_lock_guard_ctrl.sv
// Scoreboard bench for lock_guard_ctrl with TICK_DIV=4, OPEN_TICKS=3,
// LOCK_TICKS=2, MAX_WRONG=3. Stimulus pushes expected forwarded keys,
// unlock window lengths and lockout length/level into queues; a monitor on
// the falling edge pops and compares whenever the DUT presents them.
module tb_lock_guard_ctrl;

  typedef struct {
    int len;
    int lvl;
  } lock_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [3:0]  code_in;
  logic        verdict_ok;
  logic        verdict_bad;
  logic        valid_out;
  logic [3:0]  code_out;
  logic        unlock;
  logic        locked_out;
  logic [3:0]  count_wrong;
  logic [1:0]  lock_level;
  logic [15:0] remain;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] key_q[$];
  int         open_q[$];
  lock_exp_t  lock_q[$];

  lock_guard_ctrl #(
    .TICK_DIV   (4),
    .OPEN_TICKS (3),
    .LOCK_TICKS (2),
    .MAX_WRONG  (3)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .code_in     (code_in),
    .verdict_ok  (verdict_ok),
    .verdict_bad (verdict_bad),
    .valid_out   (valid_out),
    .code_out    (code_out),
    .unlock      (unlock),
    .locked_out  (locked_out),
    .count_wrong (count_wrong),
    .lock_level  (lock_level),
    .remain      (remain)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  int open_len = 0;
  int lock_len = 0;
  int lvl_seen = 0;

  always @(negedge clk) begin
    if (!reset) begin
      open_len = 0;
      lock_len = 0;
    end else begin
      if (valid_out) begin
        if (key_q.size() == 0) begin
          n_checks++;
          $display("FAIL key_unexpected: got valid_out code %0h, expected no key", code_out);
        end else begin
          check("key_code", 32'(code_out), 32'(key_q.pop_front()));
        end
      end

      if (unlock) begin
        open_len++;
      end else if (open_len > 0) begin
        if (open_q.size() == 0) begin
          n_checks++;
          $display("FAIL open_unexpected: got window of %0d, expected none", open_len);
        end else begin
          check("open_len", 32'(open_len), 32'(open_q.pop_front()));
        end
        open_len = 0;
      end

      if (locked_out) begin
        lock_len++;
        lvl_seen = int'(lock_level);
      end else if (lock_len > 0) begin
        if (lock_q.size() == 0) begin
          n_checks++;
          $display("FAIL lock_unexpected: got lockout of %0d, expected none", lock_len);
        end else begin
          lock_exp_t e;
          e = lock_q.pop_front();
          check("lock_len", 32'(lock_len), 32'(e.len));
          check("lock_lvl", 32'(lvl_seen), 32'(e.lvl));
        end
        lock_len = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_key(input logic [3:0] c, input bit fwd);
    valid_in = 1'b1;
    code_in  = c;
    if (fwd) key_q.push_back(c);
    step();
    valid_in = 1'b0;
  endtask

  task automatic pulse_ok();
    verdict_ok = 1'b1;
    step();
    verdict_ok = 1'b0;
  endtask

  task automatic pulse_bad();
    verdict_bad = 1'b1;
    step();
    verdict_bad = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_out"},  32'(valid_out),   0);
    check({tag, "_code_out"},   32'(code_out),    0);
    check({tag, "_unlock"},     32'(unlock),      0);
    check({tag, "_locked_out"}, 32'(locked_out),  0);
    check({tag, "_count"},      32'(count_wrong), 0);
    check({tag, "_level"},      32'(lock_level),  0);
    check({tag, "_remain"},     32'(remain),      0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scenarios ----------------
  initial begin
    reset       = 1'b0;
    valid_in    = 1'b0;
    code_in     = 4'h0;
    verdict_ok  = 1'b0;
    verdict_bad = 1'b0;
    #12;
    check_all_zero("reset");
    step(2);
    reset = 1'b1;
    step(6);

    // 1. pass-through in IDLE
    send_key(4'h5, 1'b1);
    step(2);

    // 2. unlock window: 12 cycles, remain 3 -> 2 -> 1 -> 0
    open_q.push_back(12);
    pulse_ok();
    check("open_unlock", 32'(unlock), 1);
    check("open_remain3", 32'(remain), 3);
    check("open_count", 32'(count_wrong), 0);
    step(4);
    check("open_remain2", 32'(remain), 2);
    step(4);
    check("open_remain1", 32'(remain), 1);
    step(4);
    check("open_expired_unlock", 32'(unlock), 0);
    check("open_expired_remain", 32'(remain), 0);
    step(2);

    // 3. relock: key forwarded in OPEN, then 4'hB consumed
    open_q.push_back(2);
    pulse_ok();
    send_key(4'h2, 1'b1);
    send_key(4'hB, 1'b0);
    check("relock_unlock", 32'(unlock), 0);
    check("relock_remain", 32'(remain), 0);
    send_key(4'h7, 1'b1);
    step(2);

    // 4. three bad verdicts -> 8-cycle lockout at level 1
    pulse_bad();
    check("bad1_count", 32'(count_wrong), 1);
    pulse_bad();
    check("bad2_count", 32'(count_wrong), 2);
    check("bad2_locked", 32'(locked_out), 0);
    lock_q.push_back('{len: 8, lvl: 1});
    verdict_bad = 1'b1;
    send_key(4'h3, 1'b1);           // entry cycle still forwards
    verdict_bad = 1'b0;
    check("bad3_count", 32'(count_wrong), 3);
    check("bad3_locked", 32'(locked_out), 1);
    check("bad3_level", 32'(lock_level), 1);
    check("bad3_remain", 32'(remain), 2);
    send_key(4'h9, 1'b0);
    send_key(4'h8, 1'b0);
    step(5);
    send_key(4'hC, 1'b0);           // exit cycle drops the key
    check("lock1_exit_locked", 32'(locked_out), 0);
    check("lock1_exit_count", 32'(count_wrong), 0);
    check("lock1_exit_level", 32'(lock_level), 1);
    step(2);

    // 5. escalation: 16-cycle lockout at level 2, then ok clears level
    pulse_bad();
    pulse_bad();
    lock_q.push_back('{len: 16, lvl: 2});
    pulse_bad();
    check("esc_level", 32'(lock_level), 2);
    check("esc_remain", 32'(remain), 4);
    step(15);
    check("esc_still_locked", 32'(locked_out), 1);
    step();
    check("esc_exit_locked", 32'(locked_out), 0);
    check("esc_exit_level", 32'(lock_level), 2);
    open_q.push_back(1);
    pulse_ok();
    check("esc_ok_level", 32'(lock_level), 0);
    check("esc_ok_unlock", 32'(unlock), 1);
    send_key(4'hB, 1'b0);
    verdict_ok  = 1'b1;
    verdict_bad = 1'b1;
    step();
    verdict_ok  = 1'b0;
    verdict_bad = 1'b0;
    check("both_count", 32'(count_wrong), 1);
    check("both_unlock", 32'(unlock), 0);

    // 6. reset mid-LOCKOUT (no lockout length expected)
    pulse_bad();
    pulse_bad();
    check("pre_reset_locked", 32'(locked_out), 1);
    step(2);
    reset = 1'b0;
    #1;
    check("async_reset_locked", 32'(locked_out), 0);
    check("async_reset_level", 32'(lock_level), 0);
    check("async_reset_count", 32'(count_wrong), 0);
    check("async_reset_remain", 32'(remain), 0);
    step(2);
    reset = 1'b1;
    step();
    send_key(4'h6, 1'b1);
    check("post_reset_valid", 32'(valid_out), 1);
    check("post_reset_code", 32'(code_out), 32'h6);
    step(3);

    check("key_q_drained", 32'(key_q.size()), 0);
    check("open_q_drained", 32'(open_q.size()), 0);
    check("lock_q_drained", 32'(lock_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
